// File: rtl/led_status_pkg.sv
// -----------------------------------------------------------------------------
// led_status_pkg
// Shared definitions for the LED status driver.
//   - MODE_OFF / MODE_ON / MODE_STRETCH / MODE_BLINK : 2-bit per-channel mode codes
//   - ch_state_t : stretch state of one channel (CH_IDLE, CH_HOLD)
//   - cnt_width() : bits needed for a counter that runs 0..count-1 (minimum 1)
// -----------------------------------------------------------------------------
package led_status_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_OFF     = 2'b00;
   localparam mode_t MODE_ON      = 2'b01;
   localparam mode_t MODE_STRETCH = 2'b10;
   localparam mode_t MODE_BLINK   = 2'b11;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_HOLD = 1'b1
   } ch_state_t;

   // Width of a counter holding the values 0..count-1; never narrower than 1 bit.
   function automatic int cnt_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// One LED channel: decodes the channel mode and owns the STRETCH state machine
// and its hold counter. The LED output is registered.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   mode         in   2-bit mode: OFF, ON, STRETCH, BLINK
//   evt          in   event level/pulse for STRETCH mode
//   tick         in   one-cycle timebase pulse
//   blink_phase  in   shared blink phase
//   gate         in   brightness gate (constant 1 when PWM is not built)
//   led          out  registered LED drive, active-high
// -----------------------------------------------------------------------------
module led_channel
   import led_status_pkg::*;
#(
   parameter int STRETCH_T = 50
) (
   input  logic  clk,
   input  logic  reset,
   input  mode_t mode,
   input  logic  evt,
   input  logic  tick,
   input  logic  blink_phase,
   input  logic  gate,
   output logic  led
);

   localparam int            SW     = cnt_width(STRETCH_T + 1);
   localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_T);

   ch_state_t     st_q, st_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          out_d;

   // Any mode other than STRETCH leaves state IDLE and the counter cleared, so a
   // mode change aborts a running hold and STRETCH is always entered from IDLE.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      st_d  = CH_IDLE;
      cnt_d = '0;
      out_d = 1'b0;
      unique case (mode)
         MODE_ON:    out_d = 1'b1;
         MODE_BLINK: out_d = blink_phase;
         MODE_STRETCH: begin
            st_d  = st_q;
            cnt_d = cnt_q;
            unique case (st_q)
               CH_IDLE: begin
                  if (evt) begin
                     st_d  = CH_HOLD;
                     cnt_d = S_LOAD;
                  end
               end
               CH_HOLD: begin
                  // Retrigger takes priority over both expiry and the tick decrement.
                  if (evt) begin
                     cnt_d = S_LOAD;
                  end else if (cnt_q == '0) begin
                     st_d = CH_IDLE;
                  end else if (tick) begin
                     cnt_d = cnt_q - SW'(1);
                  end
               end
               default: st_d = CH_IDLE;
            endcase
            out_d = (st_d == CH_HOLD);
         end
         default: out_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the values from before this edge, independent of statement order.
      if (reset) begin
         st_q  <= CH_IDLE;
         cnt_q <= '0;
         led   <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         led   <= out_d & gate;
      end
   end

endmodule

// File: rtl/led_status_driver.sv
// -----------------------------------------------------------------------------
// led_status_driver
// Board status indicator: NUM_LED channels, each off, on, event-stretched or
// blinking, plus a heartbeat divided down from an asynchronous slow clock.
// Holds the shared timebase prescaler, blink generator, heartbeat divider and
// optional PWM; per-channel behaviour lives in led_channel.
// Build option: define LED_PWM_EN to add the brightness port and PWM dimming.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   mode         in   2*NUM_LED  per channel [2i+1:2i]: 00 OFF, 01 ON, 10 STRETCH, 11 BLINK
//   evt          in   NUM_LED    per-channel event (named evt: 'event' is a reserved word)
//   half_period  in   BLINK_W    shared blink half-period in ticks; 0 behaves as 1
//   hb_src       in   1          asynchronous slow clock for the heartbeat
//   brightness   in   PWM_W      global duty (LED_PWM_EN only)
//   led          out  NUM_LED    registered LED drive, active-high
//   heartbeat    out  1          registered heartbeat square wave
//   tick         out  1          one-cycle timebase pulse
// -----------------------------------------------------------------------------
module led_status_driver
   import led_status_pkg::*;
#(
   parameter int NUM_LED   = 4,
   parameter int CLK_HZ    = 100000000,
   parameter int TICK_HZ   = 1000,
   parameter int STRETCH_T = 50,
   parameter int BLINK_W   = 16,
   parameter int HB_DIV    = 10000000,
   parameter int PWM_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2*NUM_LED-1:0] mode,
   input  logic [NUM_LED-1:0]   evt,
   input  logic [BLINK_W-1:0]   half_period,
   input  logic                 hb_src,
`ifdef LED_PWM_EN
   input  logic [PWM_W-1:0]     brightness,
`endif
   output logic [NUM_LED-1:0]   led,
   output logic                 heartbeat,
   output logic                 tick
);

   // ---------------------------------------------------------------- timebase
   localparam int               PRE_N   = CLK_HZ / TICK_HZ;
   localparam int               PRE_W   = cnt_width(PRE_N);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_N - 1);

   logic [PRE_W-1:0] pre_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (pre_cnt == PRE_MAX) begin
         pre_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
         tick    <= 1'b0;
      end
   end

   // ------------------------------------------------------------------- blink
   logic [BLINK_W-1:0] blink_cnt;
   logic [BLINK_W-1:0] blink_last;
   logic               blink_phase;

   // A zero half-period is treated as one tick.
   assign blink_last = (half_period == '0) ? '0 : half_period - BLINK_W'(1);

   // The >= compare lets a shortened half-period wrap on the very next tick
   // instead of running the counter all the way round.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (tick) begin
         if (blink_cnt >= blink_last) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   // --------------------------------------------------------------- heartbeat
   localparam int              HB_W   = cnt_width(HB_DIV);
   localparam logic [HB_W-1:0] HB_MAX = HB_W'(HB_DIV - 1);

   logic            hb_s1, hb_s2, hb_s3;
   logic            hb_rise;
   logic [HB_W-1:0] hb_cnt;

   // hb_s1/hb_s2 synchronise the asynchronous source; hb_s3 holds the previous
   // synchronised level for edge detection.
   assign hb_rise = hb_s2 & ~hb_s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         hb_s1     <= 1'b0;
         hb_s2     <= 1'b0;
         hb_s3     <= 1'b0;
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end else begin
         hb_s1 <= hb_src;
         hb_s2 <= hb_s1;
         hb_s3 <= hb_s2;
         if (hb_rise) begin
            if (hb_cnt == HB_MAX) begin
               hb_cnt    <= '0;
               heartbeat <= ~heartbeat;
            end else begin
               hb_cnt <= hb_cnt + HB_W'(1);
            end
         end
      end
   end

   // --------------------------------------------------------------------- PWM
   logic gate;

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // Full-scale brightness is forced fully on; a strict compare alone would
   // leave one dark slot per PWM period.
   assign gate = (brightness == '1) || (pwm_cnt < brightness);
`else
   assign gate = 1'b1;
`endif

   // ---------------------------------------------------------------- channels
   for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
      led_channel #(
         .STRETCH_T (STRETCH_T)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .mode        (mode[2*i +: 2]),
         .evt         (evt[i]),
         .tick        (tick),
         .blink_phase (blink_phase),
         .gate        (gate),
         .led         (led[i])
      );
   end

endmodule

// File: tb/tb_led_status_driver.sv
// -----------------------------------------------------------------------------
// tb_led_status_driver
// Directed bench for led_status_driver with CLK_HZ=1000, TICK_HZ=100 (tick
// every 10 clk), STRETCH_T=3, HB_DIV=4. Inputs change and outputs are sampled
// on the falling clock edge. Cycle numbers in comments count rising edges since
// reset release; tick is high in the cycle following edges 10, 20, 30, ...
// -----------------------------------------------------------------------------
module tb_led_status_driver;

   localparam int NUM_LED = 4;
   localparam int BLINK_W = 16;
   localparam int PWM_W   = 4;

   logic                 clk;
   logic                 reset;
   logic [2*NUM_LED-1:0] mode;
   logic [NUM_LED-1:0]   evt;
   logic [BLINK_W-1:0]   half_period;
   logic                 hb_src;
   logic [PWM_W-1:0]     brightness;
   logic [NUM_LED-1:0]   led;
   logic                 heartbeat;
   logic                 tick;

   int tests;
   int fails;

   led_status_driver #(
      .NUM_LED   (NUM_LED),
      .CLK_HZ    (1000),
      .TICK_HZ   (100),
      .STRETCH_T (3),
      .BLINK_W   (BLINK_W),
      .HB_DIV    (4),
      .PWM_W     (PWM_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .evt         (evt),
      .half_period (half_period),
      .hb_src      (hb_src),
`ifdef LED_PWM_EN
      .brightness  (brightness),
`endif
      .led         (led),
      .heartbeat   (heartbeat),
      .tick        (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-clk hb_src period: 4 high, 4 low.
   task automatic hb_period();
      hb_src = 1'b1;
      step(4);
      hb_src = 1'b0;
      step(4);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      reset       = 1'b1;
      mode        = 8'b01_01_01_01;     // all ON
      evt         = '0;
      half_period = 16'd2;
      hb_src      = 1'b0;
      brightness  = 4'hF;

      // ---- 1: reset held 5 clk with all channels ON
      step(5);
      check("reset_led", 32'(led), 32'h0);
      check("reset_heartbeat", 32'(heartbeat), 32'h0);
      check("reset_tick", 32'(tick), 32'h0);
      reset = 1'b0;
      step(1);                               // c=1
      check("release_led", 32'(led), 32'hF);

      // ---- timebase
      step(8);                               // c=9
      check("tick_low_c9", 32'(tick), 32'h0);
      step(1);                               // c=10
      check("tick_high_c10", 32'(tick), 32'h1);
      step(1);                               // c=11
      check("tick_low_c11", 32'(tick), 32'h0);

      // ---- 2: ch0 STRETCH, single event pulse
      mode = 8'b01_01_01_10;
      step(1);                               // c=12
      check("stretch_idle", 32'(led), 32'hE);
      evt = 4'b0001;
      step(1);                               // c=13, HOLD cnt=3
      evt = '0;
      check("stretch_on", 32'(led), 32'hF);
      step(28);                              // c=41, cnt 3->2->1->0 at 21/31/41
      check("stretch_last", 32'(led), 32'hF);
      step(1);                               // c=42
      check("stretch_expired", 32'(led), 32'hE);

      // ---- 3: retrigger extends the hold
      evt = 4'b0001;
      step(1);                               // c=43, cnt=3
      evt = '0;
      step(18);                              // c=61, cnt=1
      evt = 4'b0001;
      step(1);                               // c=62, reload 3
      evt = '0;
      step(13);                              // c=75, past the un-retriggered end
      check("retrig_extended", 32'(led), 32'hF);
      step(5);                               // c=80, tick high now
      check("tick_high_c80", 32'(tick), 32'h1);
      evt = 4'b0001;                         // event coincides with tick
      step(1);                               // c=81, reload wins
      evt = '0;
      step(19);                              // c=100
      check("reload_wins_hold", 32'(led), 32'hF);
      step(11);                              // c=111
      check("reload_last", 32'(led), 32'hF);
      step(1);                               // c=112
      check("reload_expired", 32'(led), 32'hE);

      // ---- mode change aborts a hold
      evt = 4'b0001;
      step(1);                               // c=113
      evt = '0;
      check("hold_before_mode_change", 32'(led), 32'hF);
      mode = 8'b01_01_01_00;
      step(1);                               // c=114
      check("mode_off_abort", 32'(led), 32'hE);
      mode = 8'b01_01_01_10;
      step(1);                               // c=115
      check("reenter_stretch_idle", 32'(led), 32'hE);

      // ---- 4: all BLINK; phase toggles at 21,41,...,101 (=1),121 (=0),141 (=1)
      mode = 8'hFF;
      step(1);                               // c=116
      check("blink_start", 32'(led), 32'hF);
      step(5);                               // c=121
      check("blink_before_fall", 32'(led), 32'hF);
      step(1);                               // c=122
      check("blink_fall", 32'(led), 32'h0);
      step(19);                              // c=141
      check("blink_before_rise", 32'(led), 32'h0);
      step(1);                               // c=142
      check("blink_rise", 32'(led), 32'hF);
      half_period = '0;                      // behaves as 1: toggle every tick
      step(9);                               // c=151
      check("hp0_before_fall", 32'(led), 32'hF);
      step(1);                               // c=152
      check("hp0_fall", 32'(led), 32'h0);
      step(9);                               // c=161
      check("hp0_before_rise", 32'(led), 32'h0);
      step(1);                               // c=162
      check("hp0_rise", 32'(led), 32'hF);

      // ---- 5: heartbeat, toggles on every 4th hb_src rising edge
      repeat (3) hb_period();
      check("hb_after_3_edges", 32'(heartbeat), 32'h0);
      hb_src = 1'b1;
      step(2);                               // edge still in the synchroniser
      check("hb_sync_delay", 32'(heartbeat), 32'h0);
      step(1);
      check("hb_toggle_4th_edge", 32'(heartbeat), 32'h1);
      step(1);
      hb_src = 1'b0;
      step(4);
      step(20);                              // static source
      check("hb_hold_static", 32'(heartbeat), 32'h1);

      // ---- reset mid-operation
      reset = 1'b1;
      step(1);
      check("midreset_led", 32'(led), 32'h0);
      check("midreset_heartbeat", 32'(heartbeat), 32'h0);
      check("midreset_tick", 32'(tick), 32'h0);
      reset = 1'b0;
      step(1);
      check("post_reset_blink_phase0", 32'(led), 32'h0);
      repeat (3) hb_period();
      hb_src = 1'b1;
      step(3);
      check("hb_after_reset_4th_edge", 32'(heartbeat), 32'h1);
      hb_src = 1'b0;
      step(4);

`ifdef LED_PWM_EN
      // ---- 6: PWM dimming on ch0
      begin
         int ones;
         mode       = 8'b00_00_00_01;
         brightness = 4'd4;
         step(2);
         ones = 0;
         for (int k = 0; k < 16; k++) begin
            step(1);
            ones += int'(led[0]);
         end
         check("pwm_duty_4", 32'(ones), 32'd4);
         brightness = 4'd15;
         step(2);
         ones = 0;
         for (int k = 0; k < 16; k++) begin
            step(1);
            ones += int'(led[0]);
         end
         check("pwm_duty_15", 32'(ones), 32'd16);
         brightness = 4'd0;
         step(2);
         ones = 0;
         for (int k = 0; k < 16; k++) begin
            step(1);
            ones += int'(led[0]);
         end
         check("pwm_duty_0", 32'(ones), 32'd0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
